// File: rtl/pmu_stream_tx_if.sv
// Word stream handshake between the bitstream source (DMA/host buffer) and pmu_stream_tx.
`timescale 1ns/1ps
interface pmu_stream_tx_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] word_i;
    logic              word_valid_i;
    logic              word_ready_o;

    modport master (output word_i, word_valid_i, input word_ready_o);
    modport slave  (input word_i, word_valid_i, output word_ready_o);
endinterface

// File: rtl/pmu_stream_tx.sv
// Serialises a 64-bit header plus 64-bit configuration words (optionally each followed by
// its CRC-8) onto the PMU data/enable pins, with a one-word prefetch buffer on the input side.
`timescale 1ns/1ps
module pmu_stream_tx #(
    parameter int         WORD_W   = 64,
    parameter logic [7:0] CRC_POLY = 8'hEB
) (
    input  logic                tck_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         word_count_i,
    input  logic [31:0]         last_bits_i,
    input  logic                checksum_en_i,
    pmu_stream_tx_if.slave      word_if,
    output logic                data_o,
    output logic                en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   hdr_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [WORD_W-1:0]   buf_q;
    logic                buf_vld_q;
    logic [CNT_W-1:0]    bitcnt_q;
    logic [31:0]         wcnt_q;
    logic                chk_en_q;
    logic [7:0]          crc_q;
    logic                err_q;

    logic accept, drain, underrun, last_bit, crc_last, fill, frame_active;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    assign accept       = start_i && (word_count_i != 32'd0);
    assign last_bit     = (bitcnt_q == CNT_W'(WORD_W - 1));
    assign crc_last     = (bitcnt_q[2:0] == 3'd7);
    assign frame_active = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CRC);

    assign word_if.word_ready_o = frame_active && !buf_vld_q;
    assign fill                 = word_if.word_valid_i && word_if.word_ready_o;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Every entry into DATA pulls from the buffer; an empty buffer there aborts the frame.
    always_comb begin
        state_d  = state_q;
        drain    = 1'b0;
        underrun = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_HDR;
            S_HDR:  if (last_bit) drain = 1'b1;
            S_DATA: begin
                if (last_bit) begin
                    if (chk_en_q)               state_d = S_CRC;
                    else if (wcnt_q == 32'd1)   state_d = S_DONE;
                    else                        drain   = 1'b1;
                end
            end
            S_CRC: begin
                if (crc_last) begin
                    if (wcnt_q == 32'd0) state_d = S_DONE;
                    else                 drain   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (drain) begin
            if (buf_vld_q) begin
                state_d = S_DATA;
            end else begin
                underrun = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            bitcnt_q  <= '0;
            wcnt_q    <= '0;
            chk_en_q  <= 1'b0;
            buf_vld_q <= 1'b0;
            crc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_d != state_q) || (state_q == S_IDLE)) bitcnt_q <= '0;
            else                                             bitcnt_q <= bitcnt_q + CNT_W'(1);

            if ((state_q == S_IDLE) && accept) begin
                wcnt_q   <= word_count_i;
                chk_en_q <= checksum_en_i;
                err_q    <= 1'b0;
            end
            if (underrun) err_q <= 1'b1;
            if ((state_q == S_DATA) && last_bit) wcnt_q <= wcnt_q - 32'd1;

            if (drain && buf_vld_q)    crc_q <= 8'h00;
            else if (state_q == S_DATA) crc_q <= crc8_step(crc_q, shreg_q[0]);

            // A fill on the drain edge wins, so the buffer keeps the newly arrived word.
            if (state_d == S_IDLE) begin
                buf_vld_q <= 1'b0;
            end else begin
                if (drain) buf_vld_q <= 1'b0;
                if (fill)  buf_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge tck_i) begin
        if ((state_q == S_IDLE) && accept) hdr_q <= {last_bits_i, word_count_i};
        if (fill) buf_q <= word_if.word_i;
        if (drain)                  shreg_q <= buf_q;
        else if (state_q == S_DATA) shreg_q <= shreg_q >> 1;
    end

    always_comb begin
        data_o = 1'b0;
        case (state_q)
            S_HDR:   data_o = hdr_q[bitcnt_q];
            S_DATA:  data_o = shreg_q[0];
            S_CRC:   data_o = crc_q[3'd7 - bitcnt_q[2:0]];
            default: data_o = 1'b0;
        endcase
    end

    assign en_o   = frame_active;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;
endmodule

// File: tb/tb_pmu_stream_tx.sv
// Scoreboard bench for pmu_stream_tx: expected serial bits queued at frame start, popped per en_o cycle.
`timescale 1ns/1ps
module tb_pmu_stream_tx;
    logic        tck = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        checksum_en = 1'b0;
    logic [31:0] word_count = '0;
    logic [31:0] last_bits = '0;
    logic        data, en, busy, done, err;

    pmu_stream_tx_if wif();

    pmu_stream_tx dut (
        .tck_i        (tck),
        .rst_i        (rst),
        .start_i      (start),
        .word_count_i (word_count),
        .last_bits_i  (last_bits),
        .checksum_en_i(checksum_en),
        .word_if      (wif),
        .data_o       (data),
        .en_o         (en),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 tck = ~tck;

    int          n_checks = 0;
    int          n_errors = 0;
    int          en_cnt   = 0;
    bit          exp_q[$];
    bit          rx_q[$];
    logic [63:0] feed_q[$];
    logic [63:0] frame_words[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] c, input bit b);
        bit fb;
        fb = b ^ c[7];
        return {c[6:0], 1'b0} ^ (fb ? 8'hEB : 8'h00);
    endfunction

    function automatic logic [63:0] rx_field(input int base, input int nb);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++)
            if (base + i < rx_q.size()) v[i] = rx_q[base + i];
        return v;
    endfunction

    // Output monitor: every enabled cycle consumes one expected bit.
    always @(negedge tck) begin
        if (!rst) begin
            if (en) begin
                en_cnt++;
                rx_q.push_back(data);
                if (exp_q.size() > 0) check_eq("bit", 64'(data), 64'(exp_q.pop_front()));
            end else begin
                check_eq("data_idle", 64'(data), 64'd0);
            end
        end
    end

    // Word source: presents the head of feed_q, pops it once the handshake has completed.
    initial begin
        bit rdy_prev;
        rdy_prev         = 1'b0;
        wif.word_valid_i = 1'b0;
        wif.word_i       = '0;
        forever begin
            @(negedge tck);
            #1;
            if (wif.word_valid_i && rdy_prev && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                wif.word_valid_i = 1'b1;
                wif.word_i       = feed_q[0];
            end else begin
                wif.word_valid_i = 1'b0;
                wif.word_i       = '0;
            end
            rdy_prev = wif.word_ready_o;
        end
    end

    task automatic start_frame(input int n, input logic [31:0] last, input bit chk, input int nsent);
        logic [63:0] hdr;
        logic [7:0]  c;
        hdr = {last, 32'(n)};
        exp_q.delete();
        rx_q.delete();
        en_cnt = 0;
        for (int i = 0; i < 64; i++) exp_q.push_back(hdr[i]);
        for (int w = 0; w < nsent; w++) begin
            c = 8'h00;
            for (int i = 0; i < 64; i++) begin
                exp_q.push_back(frame_words[w][i]);
                c = crc_model(c, frame_words[w][i]);
            end
            if (chk) for (int k = 7; k >= 0; k--) exp_q.push_back(c[k]);
        end
        feed_q = frame_words;
        @(negedge tck);
        start       = 1'b1;
        word_count  = 32'(n);
        last_bits   = last;
        checksum_en = chk;
        @(negedge tck);
        start = 1'b0;
        check_eq("en_first", 64'(en), 64'd1);
        check_eq("busy_first", 64'(busy), 64'd1);
    endtask

    task automatic wait_frame(input int exp_len, input bit exp_err, input int n, input bit chk);
        int cyc;
        int dones;
        logic [7:0] r;
        cyc   = 0;
        dones = 0;
        while (!done && !err && cyc < 4000) begin
            @(negedge tck);
            cyc++;
        end
        check_eq("frame_end", 64'(done | err), 64'd1);
        if (done) dones++;
        check_eq("err_flag", 64'(err), 64'(exp_err));
        @(negedge tck);
        check_eq("done_pulse", 64'(done), 64'd0);
        check_eq("busy_end", 64'(busy), 64'd0);
        check_eq("en_len", 64'(en_cnt), 64'(exp_len));
        check_eq("bits_left", 64'(exp_q.size()), 64'd0);
        check_eq("done_seen", 64'(dones), 64'(!exp_err));
        if (chk) begin
            for (int w = 0; w < n; w++) begin
                r = 8'h00;
                for (int i = 0; i < 72; i++)
                    if (64 + 72 * w + i < rx_q.size()) r = crc_model(r, rx_q[64 + 72 * w + i]);
                check_eq("residue", 64'(r), 64'd0);
            end
        end
        feed_q.delete();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [7:0] c;
        repeat (3) @(negedge tck);
        check_eq("rst_en", 64'(en), 64'd0);
        check_eq("rst_data", 64'(data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_ready", 64'(wif.word_ready_o), 64'd0);
        rst = 1'b0;
        @(negedge tck);

        // T1: single word, no checksum, word preloaded before start
        frame_words.delete();
        frame_words.push_back(64'hA5A5_0000_FFFF_1234);
        start_frame(1, 32'd64, 1'b0, 1);
        wait_frame(128, 1'b0, 1, 1'b0);
        check_eq("t1_header", rx_field(0, 64), 64'h0000_0040_0000_0001);
        check_eq("t1_word", rx_field(64, 64), 64'hA5A5_0000_FFFF_1234);

        // T2: two words with checksum
        frame_words.delete();
        frame_words.push_back(64'h0);
        frame_words.push_back(64'h1);
        start_frame(2, 32'd64, 1'b1, 2);
        wait_frame(208, 1'b0, 2, 1'b1);
        check_eq("t2_crc0", rx_field(128, 8), 64'h00);
        c = 8'h00;
        for (int i = 0; i < 64; i++) c = crc_model(c, (i == 0));
        for (int k = 0; k < 8; k++) check_eq("t2_crc1_bit", 64'(rx_q[200 + k]), 64'(c[7 - k]));

        // T3: underrun on the second word
        frame_words.delete();
        frame_words.push_back(rnd64());
        start_frame(3, 32'd64, 1'b0, 1);
        wait_frame(128, 1'b1, 3, 1'b0);
        repeat (4) @(negedge tck);
        check_eq("t3_err_sticky", 64'(err), 64'd1);
        check_eq("t3_en_low", 64'(en), 64'd0);

        // T5a: zero-length start is ignored and leaves err_o set
        @(negedge tck);
        start      = 1'b1;
        word_count = 32'd0;
        @(negedge tck);
        start = 1'b0;
        check_eq("t5_zero_busy", 64'(busy), 64'd0);
        check_eq("t5_zero_err", 64'(err), 64'd1);

        // T4: reset mid-frame, then a clean frame
        frame_words.delete();
        frame_words.push_back(rnd64());
        frame_words.push_back(rnd64());
        start_frame(2, 32'd64, 1'b1, 2);
        repeat (98) @(negedge tck);
        rst = 1'b1;
        #1;
        check_eq("t4_rst_en", 64'(en), 64'd0);
        check_eq("t4_rst_data", 64'(data), 64'd0);
        check_eq("t4_rst_busy", 64'(busy), 64'd0);
        check_eq("t4_rst_done", 64'(done), 64'd0);
        check_eq("t4_rst_err", 64'(err), 64'd0);
        check_eq("t4_rst_ready", 64'(wif.word_ready_o), 64'd0);
        exp_q.delete();
        feed_q.delete();
        @(negedge tck);
        rst = 1'b0;
        repeat (2) @(negedge tck);
        start_frame(2, 32'd32, 1'b1, 2);
        wait_frame(208, 1'b0, 2, 1'b1);

        // T5b: start pulsed mid-frame is ignored
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back(rnd64());
        start_frame(3, 32'd17, 1'b0, 3);
        repeat (50) @(negedge tck);
        start       = 1'b1;
        word_count  = 32'd5;
        checksum_en = 1'b1;
        @(negedge tck);
        start = 1'b0;
        wait_frame(256, 1'b0, 3, 1'b0);

        // T6: continuous valid, four words with checksum, no bubbles
        frame_words.delete();
        for (int i = 0; i < 4; i++) frame_words.push_back(rnd64() ^ 64'(i));
        start_frame(4, 32'd64, 1'b1, 4);
        wait_frame(352, 1'b0, 4, 1'b1);

        repeat (2) @(negedge tck);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
